// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch
//   Multi-channel PWM generator. All channels share one period counter that
//   advances once per prescaler tick, counting either as a sawtooth
//   (edge-aligned) or as a triangle (center-aligned). Each channel compares the
//   counter against its own active duty value and applies a per-channel output
//   polarity. Duty values are double-buffered: a load goes into a shadow
//   register and only reaches the comparators at a period boundary, so a period
//   in progress is never cut short or stretched by a duty change.
//
// Parameters
//   WIDTH     duty/counter resolution in bits (MAX = 2**WIDTH-1)
//   CHANNELS  number of PWM outputs
//   PRESCALE  clk cycles per counter tick (>= 1)
//   CENTER    0 = edge-aligned sawtooth, 1 = center-aligned triangle
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   en            1 = run; 0 = hold counter at 0 and drive idle (polarity) levels
//   duty_in       duty for channel i at [i*WIDTH +: WIDTH]
//   duty_load     one-clk strobe capturing duty_in into the shadow registers
//   polarity      per-channel inversion (1 = active-low output)
//   pwm           registered PWM outputs
//   period_start  one-clk pulse marking the start of a new period
//   load_pending  shadow holds duty values not yet applied
module pwm_multi_ch #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned CENTER   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      duty_load,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic                      load_pending
);

  // The prescaler register needs at least one bit even when PRESCALE is 1.
  localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  CntMax    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CntZero   = '0;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // State
  logic [PrescW-1:0]         r_presc;
  logic [WIDTH-1:0]          r_cnt;
  dir_e                      r_dir;
  logic [CHANNELS*WIDTH-1:0] r_shadow;
  logic [CHANNELS*WIDTH-1:0] r_active;
  logic                      r_pending;
  logic [CHANNELS-1:0]       r_pwm;
  logic                      r_period_start;

  // Next-state and combinational terms
  logic [PrescW-1:0]         w_presc_d;
  logic [WIDTH-1:0]          w_cnt_d;
  dir_e                      w_dir_d;
  logic [CHANNELS*WIDTH-1:0] w_shadow_d;
  logic [CHANNELS*WIDTH-1:0] w_active_d;
  logic                      w_pending_d;
  logic [CHANNELS-1:0]       w_pwm_d;
  logic [CHANNELS-1:0]       w_raw;
  logic                      w_tick;
  logic                      w_boundary;

  // ---------------------------------------------------------------------------
  // Tick and period boundary
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tick     = en && (r_presc == PrescLast);
    w_boundary = 1'b0;
    if (CENTER != 0) begin
      // The triangle period ends on the tick that leaves the bottom endpoint
      // of the down slope.
      w_boundary = w_tick && (r_cnt == CntZero) && (r_dir == DirDown);
    end else begin
      w_boundary = w_tick && (r_cnt == CntMax);
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, counter and direction
  // ---------------------------------------------------------------------------
  always_comb begin
    w_presc_d = r_presc;
    w_cnt_d   = r_cnt;
    w_dir_d   = r_dir;
    if (!en) begin
      // Disabled: park so that enabling always starts a fresh period.
      w_presc_d = '0;
      w_cnt_d   = '0;
      w_dir_d   = DirUp;
    end else if (w_tick) begin
      w_presc_d = '0;
      if (CENTER != 0) begin
        // Each endpoint is visited once per direction: the tick at an
        // endpoint only flips the direction and leaves the count alone.
        if (r_dir == DirUp) begin
          if (r_cnt == CntMax) begin
            w_dir_d = DirDown;
          end else begin
            w_cnt_d = r_cnt + WIDTH'(1);
          end
        end else begin
          if (r_cnt == CntZero) begin
            w_dir_d = DirUp;
          end else begin
            w_cnt_d = r_cnt - WIDTH'(1);
          end
        end
      end else begin
        // Natural wrap MAX -> 0.
        w_cnt_d = r_cnt + WIDTH'(1);
      end
    end else begin
      w_presc_d = r_presc + PrescW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Duty double-buffering
  // ---------------------------------------------------------------------------
  always_comb begin
    w_shadow_d  = duty_load ? duty_in : r_shadow;
    w_active_d  = r_active;
    w_pending_d = r_pending;
    if (!en) begin
      // While idle the comparators simply follow the newest duty values.
      w_active_d  = duty_load ? duty_in : r_shadow;
      w_pending_d = 1'b0;
    end else begin
      if (duty_load) begin
        w_pending_d = 1'b1;
      end
      if (w_boundary) begin
        if (duty_load) begin
          // Load coinciding with the boundary bypasses the shadow.
          w_active_d  = duty_in;
          w_pending_d = 1'b0;
        end else if (r_pending) begin
          w_active_d  = r_shadow;
          w_pending_d = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare and output polarity
  // ---------------------------------------------------------------------------
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_raw[i] = (r_cnt < r_active[i*WIDTH +: WIDTH]);
    end
    w_pwm_d = en ? (w_raw ^ polarity) : polarity;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_dir          <= DirUp;
      r_shadow       <= '0;
      r_active       <= '0;
      r_pending      <= 1'b0;
      r_pwm          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_presc_d;
      r_cnt          <= w_cnt_d;
      r_dir          <= w_dir_d;
      r_shadow       <= w_shadow_d;
      r_active       <= w_active_d;
      r_pending      <= w_pending_d;
      r_pwm          <= w_pwm_d;
      // w_boundary already requires en, so this stays low while disabled.
      r_period_start <= w_boundary;
    end
  end

  assign pwm          = r_pwm;
  assign period_start = r_period_start;
  assign load_pending = r_pending;

endmodule
